multi_fork_avlstrm: RTL and testbench

MULTI_FORK_AVLSTRM -- requirements
Module: multi_fork_avlstrm

---
 rtl/multi_fork_avlstrm_if.sv | 18 +
 rtl/multi_fork_avlstrm.sv | 139 +++++++++++++
 tb/tb_multi_fork_avlstrm.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_fork_avlstrm_if.sv
// avl_stream_if: Avalon-ST style packet stream (data, valid, ready, sop, eop, empty).
// Handshake: a beat transfers on a rising clock edge when valid && ready are both 1.
// The source holds all fields stable while valid is high and ready is low.
interface avl_stream_if #(
  parameter int W = 32
);
  localparam int EMPTY_W = (W > 8) ? $clog2(W / 8) : 1;

  logic [W-1:0]       data;
  logic               valid;
  logic               ready;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;

  modport rx (input data, valid, sop, eop, empty, output ready);
  modport tx (output data, valid, sop, eop, empty, input ready);
endinterface

// File: rtl/multi_fork_avlstrm.sv
// multi_fork_avlstrm: steers each input packet to one of NUM_OUT outputs, or drops it, using one
// destination token per packet. Statistics counters exist only when MULTI_FORK_STATS_EN is defined.
module multi_fork_avlstrm #(
  parameter int WIDTH   = 512,
  parameter int NUM_OUT = 4,
  parameter int DEST_W  = $clog2(NUM_OUT + 1)
) (
  input  logic        Clk,
  input  logic        Rst,
  avl_stream_if.rx    in,
  avl_stream_if.rx    dest,
  avl_stream_if.tx    out [NUM_OUT],
  output logic [31:0] stats_pkt [NUM_OUT],
  output logic [31:0] stats_sop [NUM_OUT],
  output logic [31:0] stats_drop,
  output logic [31:0] stats_orphan,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  // Smallest token value that means "discard the packet".
  localparam logic [DEST_W-1:0] DROP_MIN = DEST_W'(NUM_OUT);

  logic [1:0]         state;
  logic [DEST_W-1:0]  sel;
  logic [NUM_OUT-1:0] out_ready;
  logic [NUM_OUT-1:0] sel_hit;
  logic               fwd_ready;
  logic               in_ready_c;
  logic               dest_ready_c;
  logic               in_xfer;
  logic               tok_xfer;
  logic               eop_xfer;

  for (genvar i = 0; i < NUM_OUT; i++) begin : gen_out
    assign out_ready[i] = out[i].ready;
    assign sel_hit[i]   = (sel == DEST_W'(i));
    assign out[i].data  = in.data;
    assign out[i].sop   = in.sop;
    assign out[i].eop   = in.eop;
    assign out[i].empty = in.empty;
    assign out[i].valid = !Rst && (state == S_FWD) && sel_hit[i] && in.valid;
  end

  assign fwd_ready = |(out_ready & sel_hit);

  // Everything is gated by Rst so a reset mid-packet idles the handshakes in the same cycle.
  always_comb begin
    in_ready_c   = 1'b0;
    dest_ready_c = 1'b0;
    if (!Rst) begin
      case (state)
        S_IDLE: begin
          dest_ready_c = in.valid && in.sop;
          in_ready_c   = in.valid && !in.sop;
        end
        S_FWD:   in_ready_c = fwd_ready;
        S_DROP:  in_ready_c = 1'b1;
        default: in_ready_c = 1'b0;
      endcase
    end
  end

  assign in.ready   = in_ready_c;
  assign dest.ready = dest_ready_c;
  assign in_xfer    = in.valid && in_ready_c;
  assign tok_xfer   = dest.valid && dest_ready_c;
  assign eop_xfer   = in_xfer && in.eop;
  assign fsm_state  = state;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= S_IDLE;
      sel   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tok_xfer) begin
            sel   <= dest.data;
            state <= (dest.data < DROP_MIN) ? S_FWD : S_DROP;
          end
        end
        S_FWD, S_DROP: begin
          if (eop_xfer) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MULTI_FORK_STATS_EN
  logic [31:0] drop_q;
  logic [31:0] orphan_q;

  for (genvar i = 0; i < NUM_OUT; i++) begin : gen_ch
    logic [31:0] pkt_q;
    logic [31:0] sop_q;

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        pkt_q <= '0;
        sop_q <= '0;
      end else if ((state == S_FWD) && sel_hit[i] && in_xfer) begin
        if (in.sop) sop_q <= sop_q + 32'd1;
        if (in.eop) pkt_q <= pkt_q + 32'd1;
      end
    end

    assign stats_pkt[i] = pkt_q;
    assign stats_sop[i] = sop_q;
  end

  // In IDLE only non-SOP beats are accepted, so every accepted beat there is an orphan.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      drop_q   <= '0;
      orphan_q <= '0;
    end else begin
      if ((state == S_DROP) && eop_xfer) drop_q <= drop_q + 32'd1;
      if ((state == S_IDLE) && in_xfer)  orphan_q <= orphan_q + 32'd1;
    end
  end

  assign stats_drop   = drop_q;
  assign stats_orphan = orphan_q;
`else
  for (genvar i = 0; i < NUM_OUT; i++) begin : gen_zero
    assign stats_pkt[i] = '0;
    assign stats_sop[i] = '0;
  end

  assign stats_drop   = '0;
  assign stats_orphan = '0;
`endif

endmodule

// File: tb/tb_multi_fork_avlstrm.sv
// tb_multi_fork_avlstrm: directed packet sequence for multi_fork_avlstrm with a beat scoreboard
// and a packet-level statistics model (expected zeros unless MULTI_FORK_STATS_EN is defined).
module tb_multi_fork_avlstrm;

  localparam int WIDTH   = 32;
  localparam int NUM_OUT = 4;
  localparam int DEST_W  = $clog2(NUM_OUT + 1);
  localparam int EW      = (WIDTH > 8) ? $clog2(WIDTH / 8) : 1;
  localparam int SB_W    = 4 + 2 + EW + WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

`ifdef MULTI_FORK_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  avl_stream_if #(.W(WIDTH))  in_if ();
  avl_stream_if #(.W(DEST_W)) dest_if ();
  avl_stream_if #(.W(WIDTH))  out_if [NUM_OUT] ();

  logic [31:0]        stats_pkt [NUM_OUT];
  logic [31:0]        stats_sop [NUM_OUT];
  logic [31:0]        stats_drop;
  logic [31:0]        stats_orphan;
  logic [1:0]         fsm_state;

  logic [NUM_OUT-1:0] o_ready;
  logic [NUM_OUT-1:0] o_valid;
  logic [NUM_OUT-1:0] o_sop;
  logic [NUM_OUT-1:0] o_eop;
  logic [EW-1:0]      o_empty [NUM_OUT];
  logic [WIDTH-1:0]   o_data  [NUM_OUT];

  for (genvar i = 0; i < NUM_OUT; i++) begin : gen_tap
    assign out_if[i].ready = o_ready[i];
    assign o_valid[i]      = out_if[i].valid;
    assign o_sop[i]        = out_if[i].sop;
    assign o_eop[i]        = out_if[i].eop;
    assign o_empty[i]      = out_if[i].empty;
    assign o_data[i]       = out_if[i].data;
  end

  multi_fork_avlstrm #(
    .WIDTH   (WIDTH),
    .NUM_OUT (NUM_OUT),
    .DEST_W  (DEST_W)
  ) dut (
    .Clk          (clk),
    .Rst          (rst),
    .in           (in_if),
    .dest         (dest_if),
    .out          (out_if),
    .stats_pkt    (stats_pkt),
    .stats_sop    (stats_sop),
    .stats_drop   (stats_drop),
    .stats_orphan (stats_orphan),
    .fsm_state    (fsm_state)
  );

  // scoreboard and model state
  logic [SB_W-1:0] exp_q [$];
  logic [31:0]     exp_pkt [NUM_OUT];
  logic [31:0]     exp_sop [NUM_OUT];
  logic [31:0]     exp_drop;
  logic [31:0]     exp_orphan;
  int              checks = 0;
  int              errors = 0;
  int              ready_mode = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_OUT; i++) begin
      exp_pkt[i] = '0;
      exp_sop[i] = '0;
    end
    exp_drop   = '0;
    exp_orphan = '0;
  endtask

  task automatic check_stats(input string where);
    for (int i = 0; i < NUM_OUT; i++) begin
      check($sformatf("%s_stats_pkt%0d", where, i), 64'(stats_pkt[i]), 64'(STATS_EN ? exp_pkt[i] : 32'd0));
      check($sformatf("%s_stats_sop%0d", where, i), 64'(stats_sop[i]), 64'(STATS_EN ? exp_sop[i] : 32'd0));
    end
    check({where, "_stats_drop"},   64'(stats_drop),   64'(STATS_EN ? exp_drop : 32'd0));
    check({where, "_stats_orphan"}, 64'(stats_orphan), 64'(STATS_EN ? exp_orphan : 32'd0));
  endtask

  task automatic update_ready();
    case (ready_mode)
      1:       o_ready[2] = ~o_ready[2];
      2:       o_ready = NUM_OUT'($urandom_range(0, (1 << NUM_OUT) - 1));
      default: o_ready = '1;
    endcase
  endtask

  // Pops one expected beat for every output beat that completes its handshake this cycle.
  task automatic sb_observe();
    logic [SB_W-1:0] got;
    logic [SB_W-1:0] want;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (o_valid[i] && o_ready[i]) begin
        got = {4'(i), o_sop[i], o_eop[i], o_empty[i], o_data[i]};
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'(exp_q.size()), 64'(1));
        end else begin
          want = exp_q.pop_front();
          check("sb_beat", 64'(got), 64'(want));
        end
      end
    end
  endtask

  // Drives one packet with its token; stop_after >= 0 returns after that many beats transferred.
  task automatic drive_pkt(input int tok, input int nbeats, input int stop_after);
    int               b = 0;
    int               guard = 0;
    bit               tok_pending = 1'b1;
    bit               have_beat = 1'b0;
    bit               fwd;
    bit               took;
    bit               moved;
    logic [WIDTH-1:0] d;
    logic [EW-1:0]    e;
    fwd = (tok < NUM_OUT);
    while (b < nbeats && b != stop_after && guard < 200) begin
      if (!have_beat) begin
        d = $urandom;
        e = (b == nbeats - 1) ? EW'($urandom_range(0, (1 << EW) - 1)) : '0;
        in_if.data  = d;
        in_if.sop   = (b == 0);
        in_if.eop   = (b == nbeats - 1);
        in_if.empty = e;
        in_if.valid = 1'b1;
        if (fwd) exp_q.push_back({4'(tok), (b == 0), (b == nbeats - 1), e, d});
        have_beat = 1'b1;
      end
      dest_if.valid = tok_pending;
      dest_if.data  = DEST_W'(tok);
      update_ready();
      #2;
      if (tok_pending) begin
        check("tok_dest_ready", 64'(dest_if.ready), 64'(1));
        check("tok_bubble",     64'(in_if.ready),   64'(0));
        check("tok_out_valid",  64'(o_valid),       64'(0));
        check("tok_state",      64'(fsm_state),     64'(ST_IDLE));
      end else begin
        check("pkt_dest_ready", 64'(dest_if.ready), 64'(0));
        check("pkt_in_ready",   64'(in_if.ready),   64'(fwd ? o_ready[tok] : 1'b1));
        check("pkt_out_valid",  64'(o_valid),       64'(fwd ? (NUM_OUT'(1) << tok) : NUM_OUT'(0)));
        check("pkt_state",      64'(fsm_state),     64'(fwd ? ST_FWD : ST_DROP));
      end
      sb_observe();
      took  = dest_if.valid && dest_if.ready;
      moved = in_if.valid && in_if.ready;
      @(posedge clk);
      @(negedge clk);
      if (took) tok_pending = 1'b0;
      if (moved) begin
        b++;
        have_beat = 1'b0;
      end
      guard++;
    end
    if (stop_after < 0) begin
      check("pkt_beats_done", 64'(b), 64'(nbeats));
      in_if.valid   = 1'b0;
      dest_if.valid = 1'b0;
      if (fwd) begin
        exp_sop[tok] = exp_sop[tok] + 32'd1;
        exp_pkt[tok] = exp_pkt[tok] + 32'd1;
      end else begin
        exp_drop = exp_drop + 32'd1;
      end
    end
  endtask

  task automatic drive_orphans(input int n, input bit last_eop);
    for (int k = 0; k < n; k++) begin
      in_if.data    = $urandom;
      in_if.sop     = 1'b0;
      in_if.eop     = last_eop && (k == n - 1);
      in_if.empty   = '0;
      in_if.valid   = 1'b1;
      dest_if.valid = 1'b0;
      update_ready();
      #2;
      check("orph_in_ready",   64'(in_if.ready),   64'(1));
      check("orph_dest_ready", 64'(dest_if.ready), 64'(0));
      check("orph_out_valid",  64'(o_valid),       64'(0));
      check("orph_state",      64'(fsm_state),     64'(ST_IDLE));
      @(posedge clk);
      @(negedge clk);
    end
    in_if.valid = 1'b0;
    exp_orphan  = exp_orphan + 32'(n);
  endtask

  initial begin
    clear_model();
    o_ready       = '1;
    in_if.data    = '0;
    in_if.sop     = 1'b1;
    in_if.eop     = 1'b0;
    in_if.empty   = '0;
    in_if.valid   = 1'b1;
    dest_if.data  = '0;
    dest_if.sop   = 1'b0;
    dest_if.eop   = 1'b0;
    dest_if.empty = '0;
    dest_if.valid = 1'b1;

    // reset state with a pending SOP and token on the inputs
    #2;
    check("rst_in_ready",   64'(in_if.ready),   64'(0));
    check("rst_dest_ready", 64'(dest_if.ready), 64'(0));
    check("rst_out_valid",  64'(o_valid),       64'(0));
    check("rst_state",      64'(fsm_state),     64'(ST_IDLE));
    check_stats("rst");
    in_if.valid   = 1'b0;
    dest_if.valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // one 3-beat packet to each output
    ready_mode = 0;
    for (int t = 0; t < NUM_OUT; t++) drive_pkt(t, 3, -1);
    check_stats("fanout");

    // drop token with a 5-beat packet
    drive_pkt(7, 5, -1);
    check_stats("drop");

    // output 2 backpressure toggling every cycle
    ready_mode = 1;
    drive_pkt(2, 4, -1);
    ready_mode = 0;
    check_stats("toggle");

    // back-to-back single-beat packets
    drive_pkt(1, 1, -1);
    drive_pkt(1, 1, -1);
    check_stats("single");

    // mixed tokens, lengths and backpressure
    ready_mode = 2;
    for (int p = 0; p < 8; p++) drive_pkt($urandom_range(0, (1 << DEST_W) - 1), $urandom_range(1, 4), -1);
    ready_mode = 0;
    check_stats("random");

    // beats without SOP while idle
    drive_orphans(3, 1'b0);
    check_stats("orphan");

    // reset mid-packet: two beats to out[0] delivered, then reset during the third
    drive_pkt(0, 4, 2);
    in_if.data    = $urandom;
    in_if.sop     = 1'b0;
    in_if.eop     = 1'b0;
    in_if.valid   = 1'b1;
    dest_if.valid = 1'b0;
    rst = 1'b1;
    #2;
    check("midrst_in_ready",   64'(in_if.ready),   64'(0));
    check("midrst_dest_ready", 64'(dest_if.ready), 64'(0));
    check("midrst_out_valid",  64'(o_valid),       64'(0));
    check("midrst_state",      64'(fsm_state),     64'(ST_IDLE));
    clear_model();
    check_stats("midrst");
    @(negedge clk);
    rst = 1'b0;
    drive_orphans(2, 1'b1);
    check_stats("after_rst");

`ifdef MULTI_FORK_STATS_EN
    // counter wrap from a forced all-ones preset
    force dut.gen_ch[0].pkt_q = 32'hFFFF_FFFF;
    #1;
    release dut.gen_ch[0].pkt_q;
    exp_pkt[0] = 32'hFFFF_FFFF;
    check("wrap_preset", 64'(stats_pkt[0]), 64'(32'hFFFF_FFFF));
    drive_pkt(0, 3, -1);
    check_stats("wrap");
`endif

    check("sb_drain", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
